// File: rtl/mult_defs_pkg.sv
// Shared definitions for the sequential multiply engine.
//   - state_t  : controller FSM encoding (IDLE / RUN / DONE)
//   - REQ0/REQ1: requester identifiers carried on res_id
//   - arb_pick : round-robin choice between the two requesters
package mult_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Returns the requester to grant. With both valid, the one that did not
  // win last time is chosen; with only one valid, that one wins.
  function automatic logic arb_pick(input logic v0, input logic v1, input logic last);
    logic pick;
    if (v0 && v1) begin
      pick = ~last;
    end else if (v1) begin
      pick = REQ1;
    end else begin
      pick = REQ0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath: one 2N-bit adder plus shift registers.
// Ports:
//   clock, reset   : system clock, async active-high reset
//   load           : capture a_in (zero-extended) into A, b_in into B, clear P
//   step           : one iteration: P += A when B[0], A <<= 1, B >>= 1
//   a_in, b_in     : operands (N bits)
//   p_sum          : P value after the current step (P + (B[0] ? A : 0))
module mult_shift_add_dp
  import mult_defs_pkg::*;
#(
  parameter int N = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [N-1:0]     a_in,
  input  logic [N-1:0]     b_in,
  output logic [2*N-1:0]   p_sum
);

  logic [2*N-1:0] r_a;
  logic [N-1:0]   r_b;
  logic [2*N-1:0] r_p;
  logic [2*N-1:0] w_addend;

  // Partial product for this iteration is A gated by the current multiplier bit.
  always_comb begin
    w_addend = '0;
    if (r_b[0]) begin
      w_addend = r_a;
    end else begin
      w_addend = '0;
    end
    // Product of two N-bit values fits in 2N bits, so no carry-out is kept.
    p_sum = r_p + w_addend;
  end

  // A/B/P registers: load on accept, advance one bit per step, otherwise hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_p <= '0;
    end else if (load) begin
      r_a <= {{N{1'b0}}, a_in};
      r_b <= b_in;
      r_p <= '0;
    end else if (step) begin
      r_a <= r_a << 1;
      r_b <= r_b >> 1;
      r_p <= p_sum;
    end else begin
      r_a <= r_a;
      r_b <= r_b;
      r_p <= r_p;
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Shared iterative multiplier with two round-robin requesters.
// A request is accepted in IDLE, the datapath runs exactly N shift-add steps
// in RUN, and the product is presented in DONE until the consumer takes it.
// Ports:
//   clock, reset            : system clock, async active-high reset
//   reqX_valid/ready/a/b    : requester X operand handshake (X = 0, 1)
//   res_valid/ready         : result handshake
//   res_p                   : 2N-bit unsigned product
//   res_id                  : requester that issued the product
module mult_seq_ctrl
  import mult_defs_pkg::*;
#(
  parameter int N = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2*N-1:0]   res_p,
  output logic             res_id
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_count;
  logic             r_last_grant;

  logic             w_grant_any;
  logic             w_grant_id;
  logic             w_accept;
  logic             w_step;
  logic             w_last_step;
  logic [N-1:0]     w_a_sel;
  logic [N-1:0]     w_b_sel;
  logic [2*N-1:0]   w_p_sum;

  mult_shift_add_dp #(.N(N)) u_dp (
    .clock (clock),
    .reset (reset),
    .load  (w_accept),
    .step  (w_step),
    .a_in  (w_a_sel),
    .b_in  (w_b_sel),
    .p_sum (w_p_sum)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last_step) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        // Returning to IDLE here means the next accept is one cycle later,
        // never in the same cycle as the result handshake.
        if (res_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Output/control decode: arbitration, readies, operand mux, datapath strobes.
  always_comb begin
    w_grant_id  = arb_pick(req0_valid, req1_valid, r_last_grant);
    // Readies are forced low while reset is held, not only after it.
    w_grant_any = (r_state == ST_IDLE) && !reset && (req0_valid || req1_valid);
    w_accept    = w_grant_any;
    req0_ready  = w_grant_any && (w_grant_id == REQ0);
    req1_ready  = w_grant_any && (w_grant_id == REQ1);
    if (w_grant_id == REQ1) begin
      w_a_sel = req1_a;
      w_b_sel = req1_b;
    end else begin
      w_a_sel = req0_a;
      w_b_sel = req0_b;
    end
    w_step      = (r_state == ST_RUN);
    w_last_step = (r_state == ST_RUN) && (r_count == LAST_COUNT);
  end

  // Step counter, arbitration history and registered result outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count      <= '0;
      r_last_grant <= REQ1;
      res_valid    <= 1'b0;
      res_p        <= '0;
      res_id       <= REQ0;
    end else begin
      if (w_accept) begin
        r_count      <= '0;
        r_last_grant <= w_grant_id;
        res_id       <= w_grant_id;
      end else if (w_step) begin
        r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        r_count <= r_count;
      end

      if (w_last_step) begin
        res_valid <= 1'b1;
        res_p     <= w_p_sum;
      end else if ((r_state == ST_DONE) && res_ready) begin
        // res_p intentionally keeps its value after the handshake.
        res_valid <= 1'b0;
      end else begin
        res_valid <= res_valid;
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

  logic        clock;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_a, req0_b, req1_a, req1_b;
  logic        res_valid, res_ready;
  logic [7:0]  res_p;
  logic        res_id;

  // Second instance at N=8 for the wide-operand case.
  logic        w8_req0_valid, w8_req0_ready, w8_req1_ready;
  logic [7:0]  w8_req0_a, w8_req0_b, w8_req1_a, w8_req1_b;
  logic        w8_req1_valid;
  logic        w8_res_valid, w8_res_id;
  logic [15:0] w8_res_p;

  int vectors;
  int miscompares;

  mult_seq_ctrl #(.N(4)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p), .res_id(res_id)
  );

  mult_seq_ctrl #(.N(8)) dut8 (
    .clock(clock), .reset(reset),
    .req0_valid(w8_req0_valid), .req0_ready(w8_req0_ready), .req0_a(w8_req0_a), .req0_b(w8_req0_b),
    .req1_valid(w8_req1_valid), .req1_ready(w8_req1_ready), .req1_a(w8_req1_a), .req1_b(w8_req1_b),
    .res_valid(w8_res_valid), .res_ready(1'b1), .res_p(w8_res_p), .res_id(w8_res_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands, wait (bounded) for ready, let the accepting edge pass.
  task automatic issue(input logic id, input logic [3:0] a, input logic [3:0] b);
    logic ok;
    if (id) begin
      req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
    #1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    chk("grant", {31'd0, ok}, 32'd1);
    @(posedge clock); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Count rising edges until res_valid is seen (bounded).
  task automatic wait_res(output int lat);
    lat = 0;
    while (res_valid !== 1'b1 && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 4'd0; req0_b = 4'd0; req1_a = 4'd0; req1_b = 4'd0;
    res_ready = 1'b1;
    w8_req0_valid = 1'b0; w8_req1_valid = 1'b0;
    w8_req0_a = 8'd0; w8_req0_b = 8'd0; w8_req1_a = 8'd0; w8_req1_b = 8'd0;

    // Reset state; readies stay low while reset is high even with valid set.
    req0_valid = 1'b1;
    @(negedge clock);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_p", {24'd0, res_p}, 32'd0);
    chk("rst_id", {31'd0, res_id}, 32'd0);
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    req0_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // req0 only, 15*15.
    issue(1'b0, 4'd15, 4'd15);
    chk("t1_ready_drop", {31'd0, req0_ready}, 32'd0);
    wait_res(lat);
    chk("t1_lat", lat, 32'd4);
    chk("t1_p", {24'd0, res_p}, 32'd225);
    chk("t1_id", {31'd0, res_id}, 32'd0);
    @(posedge clock); #1;
    chk("t1_taken", {31'd0, res_valid}, 32'd0);

    // req1 only, 0*9 then 9*0.
    issue(1'b1, 4'd0, 4'd9);
    wait_res(lat);
    chk("t2a_lat", lat, 32'd4);
    chk("t2a_p", {24'd0, res_p}, 32'd0);
    chk("t2a_id", {31'd0, res_id}, 32'd1);
    @(posedge clock); #1;
    issue(1'b1, 4'd9, 4'd0);
    wait_res(lat);
    chk("t2b_lat", lat, 32'd4);
    chk("t2b_p", {24'd0, res_p}, 32'd0);
    chk("t2b_id", {31'd0, res_id}, 32'd1);
    @(posedge clock); #1;

    // Both valid continuously: alternate req0 (15) and req1 (42).
    req0_a = 4'd3; req0_b = 4'd5; req1_a = 4'd7; req1_b = 4'd6;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("t3_first_r0", {31'd0, req0_ready}, 32'd1);
    chk("t3_first_r1", {31'd0, req1_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      wait_res(lat);
      chk("t3_lat", lat, 32'd5);
      chk("t3_id", {31'd0, res_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("t3_p", {24'd0, res_p}, (i % 2 == 0) ? 32'd15 : 32'd42);
      @(posedge clock); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clock); #1;

    // Back-pressure: 12*11 held for 10 cycles with a competing request.
    res_ready = 1'b0;
    issue(1'b0, 4'd12, 4'd11);
    wait_res(lat);
    chk("t4_lat", lat, 32'd4);
    req1_a = 4'd1; req1_b = 4'd1; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk("t4_hold_v", {31'd0, res_valid}, 32'd1);
      chk("t4_hold_p", {24'd0, res_p}, 32'd132);
      chk("t4_hold_id", {31'd0, res_id}, 32'd0);
      chk("t4_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clock); #1;
    req1_valid = 1'b0;
    chk("t4_done", {31'd0, res_valid}, 32'd0);
    chk("t4_p_kept", {24'd0, res_p}, 32'd132);
    @(posedge clock); #1;

    // Reset during the second RUN cycle of 13*13.
    issue(1'b0, 4'd13, 4'd13);
    @(posedge clock); #1;
    reset = 1'b1;
    req0_valid = 1'b1;
    #1;
    chk("t5_rst_v", {31'd0, res_valid}, 32'd0);
    chk("t5_rst_p", {24'd0, res_p}, 32'd0);
    chk("t5_rst_ready", {31'd0, req0_ready}, 32'd0);
    req0_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (res_valid !== 1'b0) lat++;
    end
    chk("t5_no_result", lat, 32'd0);
    issue(1'b0, 4'd2, 4'd3);
    wait_res(lat);
    chk("t5_lat", lat, 32'd4);
    chk("t5_p", {24'd0, res_p}, 32'd6);
    chk("t5_id", {31'd0, res_id}, 32'd0);
    @(posedge clock); #1;

    // N=8 instance: 255*255.
    w8_req0_a = 8'd255; w8_req0_b = 8'd255; w8_req0_valid = 1'b1;
    #1;
    chk("t6_ready", {31'd0, w8_req0_ready}, 32'd1);
    @(posedge clock); #1;
    w8_req0_valid = 1'b0;
    lat = 0;
    while (w8_res_valid !== 1'b1 && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("t6_lat", lat, 32'd8);
    chk("t6_p", {16'd0, w8_res_p}, 32'd65025);
    chk("t6_id", {31'd0, w8_res_id}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
